uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit path (debounced/one-shot start plus tx_fsm) between N_REQ byte producers.
- Grants one requester per UART frame, latches its byte, and issues a one-cycle start pulse plus stable data to tx_fsm.
- tx_fsm has no busy/done output, so the block times the frame itself from clock and baud parameters.
- Sits between client logic and tx_fsm in UART_top, replacing the push-button start path when the UART is driven by logic.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx_fsm among N_REQ byte producers; grant to tx_start/ack is one cycle, frame timed locally.
// Requests are sampled only in IDLE and held off for a full frame; define UART_ARB_FIXED_PRIO_EN for fixed priority.
module uart_tx_arbiter #(
  parameter int clk_freq_Hz = 1000000,
  parameter int baud_rate   = 100000,
  parameter int N_REQ       = 4,
  parameter int GUARD_CLKS  = 2,
  localparam int IDW        = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   data_in,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clk_freq_Hz / baud_rate;
  localparam int FRAME_CLKS   = CLKS_PER_BIT * 10 + GUARD_CLKS;
  localparam int CW           = $clog2(FRAME_CLKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_ack;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic [IDW-1:0]   r_grant_id;
  logic             r_busy;

  logic [IDW-1:0]   w_winner;
  logic [IDW:0]     w_idx;
  logic [7:0]       w_win_byte;
  logic             w_grant;
  logic [N_REQ-1:0] w_ack_nxt;
  logic             w_busy_nxt;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest set index is the last writer.
  always_comb begin
    w_winner = '0;
    w_idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = (IDW+1)'(i);
      if (req[w_idx[IDW-1:0]]) w_winner = w_idx[IDW-1:0];
    end
  end
`else
  logic [IDW-1:0] r_ptr;
  logic           w_found;

  // Scan from the pointer upward with wrap; first set bit wins.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(N_REQ)) w_idx = w_idx - (IDW+1)'(N_REQ);
      if (!w_found && req[w_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_winner == IDW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
    end
  end
`endif

  always_comb begin
    w_win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == IDW'(i)) w_win_byte = data_in[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_next_state = S_START;
      S_START: w_next_state = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobes are computed one cycle early so they leave the block from flops.
  always_comb begin
    w_grant    = (r_state == S_IDLE) && (|req);
    w_ack_nxt  = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_winner) : '0;
    w_busy_nxt = (w_next_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt      <= '0;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_ack      <= w_ack_nxt;
      r_tx_start <= w_grant;
      r_busy     <= w_busy_nxt;
      if (w_grant) begin
        r_tx_data  <= w_win_byte;
        r_grant_id <= w_winner;
      end
      if (r_state == S_START)                 r_cnt <= CW'(FRAME_CLKS - 1);
      else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign ack      = r_ack;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at default parameters (CLKS_PER_BIT=10, FRAME_CLKS=102).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        RSTn;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_arbiter dut (
    .clk      (clk),
    .RSTn     (RSTn),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until tx_start is seen; bounded.
  task automatic wait_start(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (tx_start) break;
    end
    if (!tx_start) chk({tag, "_timeout"}, {31'b0, tx_start}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) chk({tag, "_timeout"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    RSTn    = 1'b0;
    req     = 4'b0000;
    data_in = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst_ack",      {28'b0, ack},      32'd0);
    chk("rst_tx_data",  {24'b0, tx_data},  32'h00);
    chk("rst_grant_id", {30'b0, grant_id}, 32'd0);
    chk("rst_busy",     {31'b0, busy},     32'd0);
    RSTn = 1'b1;
    @(negedge clk);

    // Single request from requester 1.
    data_in[15:8] = 8'hA5;
    req = 4'b0010;
    @(negedge clk);
    chk("t1_tx_start", {31'b0, tx_start}, 32'd1);
    chk("t1_ack",      {28'b0, ack},      32'b0010);
    chk("t1_tx_data",  {24'b0, tx_data},  32'hA5);
    chk("t1_grant_id", {30'b0, grant_id}, 32'd1);
    chk("t1_busy",     {31'b0, busy},     32'd1);
    req = 4'b0000;
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("t1_busy_len",  n,                   32'd103);
    chk("t1_idle_strt", {31'b0, tx_start},   32'd0);
    chk("t1_idle_ack",  {28'b0, ack},        32'd0);

    RSTn = 1'b0;
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);

    data_in = 32'h13121110;
`ifdef UART_ARB_FIXED_PRIO_EN
    req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      wait_start("fp_start", n);
      if (g > 0) chk("fp_spacing", n, 32'd104);
      chk("fp_grant_id", {30'b0, grant_id}, 32'd1);
      chk("fp_ack",      {28'b0, ack},      32'b0010);
      chk("fp_tx_data",  {24'b0, tx_data},  32'h11);
    end
`else
    // All four held high; the pointer after reset starts at 0.
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start("rr_start", n);
      if (g > 0) chk("rr_spacing", n, 32'd104);
      chk("rr_grant_id", {30'b0, grant_id}, g % 4);
      chk("rr_ack",      {28'b0, ack},      32'd1 << (g % 4));
      chk("rr_tx_data",  {24'b0, tx_data},  32'h10 + (g % 4));
    end
`endif
    req = 4'b0000;

    // Request arrives 30 cycles into WAIT: next start is 104 cycles after the previous one.
    repeat (30) @(negedge clk);
    data_in[23:16] = 8'h77;
    req = 4'b0100;
    wait_start("mw_start", n);
    chk("mw_latency",  n,                  32'd74);
    chk("mw_grant_id", {30'b0, grant_id},  32'd2);
    chk("mw_ack",      {28'b0, ack},       32'b0100);
    chk("mw_tx_data",  {24'b0, tx_data},   32'h77);
    req = 4'b0000;

    // Reset 50 cycles into WAIT with requester 3 pending.
    repeat (50) @(negedge clk);
    data_in[31:24] = 8'h3C;
    req  = 4'b1000;
    RSTn = 1'b0;
    #1;
    chk("mr_tx_start", {31'b0, tx_start}, 32'd0);
    chk("mr_ack",      {28'b0, ack},      32'd0);
    chk("mr_tx_data",  {24'b0, tx_data},  32'h00);
    chk("mr_grant_id", {30'b0, grant_id}, 32'd0);
    chk("mr_busy",     {31'b0, busy},     32'd0);
    repeat (2) @(negedge clk);
    chk("mr_hold_start", {31'b0, tx_start}, 32'd0);
    RSTn = 1'b1;
    @(negedge clk);
    chk("mr_rel_start",    {31'b0, tx_start}, 32'd1);
    chk("mr_rel_ack",      {28'b0, ack},      32'b1000);
    chk("mr_rel_grant_id", {30'b0, grant_id}, 32'd3);
    chk("mr_rel_tx_data",  {24'b0, tx_data},  32'h3C);
    req = 4'b0000;

    // Quiet period.
    wait_idle("quiet_wait");
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_start || (ack != 4'b0000) || busy) bad++;
    end
    chk("quiet_strobes", bad,               32'd0);
    chk("quiet_tx_data", {24'b0, tx_data},  32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
